// File: rtl/csr_excp_ctrl.sv
// Control/status registers, exception entry/return sequencing and front-end redirect.
// Optional down-counting timer (TCFG/TVAL/TICLR, ESTAT.IS[11]) is built when CSR_TIMER_EN is defined.
module csr_excp_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_we_i,
   input  logic [13:0] csr_waddr_i,
   input  logic [31:0] csr_wdata_i,
   input  logic [13:0] csr_raddr_i,
   output logic [31:0] csr_rdata_o,
   output logic [1:0]  cpu_level_o,
   input  logic        excep_en_i,
   input  logic [5:0]  excep_ecode_i,
   input  logic [8:0]  excep_esubcode_i,
   input  logic [31:0] excep_pc_i,
   input  logic        excep_badv_we_i,
   input  logic [31:0] excep_badv_wdata_i,
   input  logic        ertn_en_i,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o,
   input  logic        preif_ready_i,
   output logic        int_req_o
);

   // state | meaning
   // IDLE  | no redirect pending, exception/ertn requests accepted
   // REDIR | redirect_pc_o presented until the fetch stage takes it
   typedef enum logic {IDLE = 1'b0, REDIR = 1'b1} state_t;

   localparam logic [13:0] ADDR_CRMD   = 14'h000;
   localparam logic [13:0] ADDR_PRMD   = 14'h001;
   localparam logic [13:0] ADDR_ECFG   = 14'h004;
   localparam logic [13:0] ADDR_ESTAT  = 14'h005;
   localparam logic [13:0] ADDR_ERA    = 14'h006;
   localparam logic [13:0] ADDR_BADV   = 14'h007;
   localparam logic [13:0] ADDR_EENTRY = 14'h00C;
   localparam logic [13:0] ADDR_TID    = 14'h040;
   localparam logic [13:0] ADDR_TCFG   = 14'h041;
   localparam logic [13:0] ADDR_TVAL   = 14'h042;
   localparam logic [13:0] ADDR_TICLR  = 14'h044;

   state_t      state_q, state_d;
   logic [1:0]  crmd_plv, prmd_pplv, is_sw;
   logic        crmd_ie, crmd_da, prmd_pie;
   logic [12:0] ecfg_lie, estat_is;
   logic [5:0]  estat_ecode;
   logic [8:0]  estat_esubcode;
   logic [31:0] era, badv, tid, tcfg, tval;
   logic [25:0] eentry_hi;
   logic        is_ti;
   logic        exc_act, ertn_act, csr_we_eff;

   // The pipeline is flushed while a redirect is pending, so requests are only honoured in IDLE.
   assign exc_act    = excep_en_i && (state_q == IDLE);
   assign ertn_act   = ertn_en_i && !excep_en_i && (state_q == IDLE);
   assign csr_we_eff = csr_we_i && !exc_act && !ertn_act;
   assign estat_is   = {1'b0, is_ti, 9'b0, is_sw};
   assign cpu_level_o = crmd_plv;

   always_ff @(posedge clk) begin
      if (rst) begin
         crmd_plv       <= 2'd0;
         crmd_ie        <= 1'b0;
         crmd_da        <= 1'b1;
         prmd_pplv      <= 2'd0;
         prmd_pie       <= 1'b0;
         ecfg_lie       <= 13'd0;
         is_sw          <= 2'd0;
         estat_ecode    <= 6'd0;
         estat_esubcode <= 9'd0;
         era            <= 32'd0;
         badv           <= 32'd0;
         eentry_hi      <= 26'd0;
         tid            <= 32'd0;
      end else if (exc_act) begin
         prmd_pplv      <= crmd_plv;
         prmd_pie       <= crmd_ie;
         crmd_plv       <= 2'd0;
         crmd_ie        <= 1'b0;
         era            <= excep_pc_i;
         estat_ecode    <= excep_ecode_i;
         estat_esubcode <= excep_esubcode_i;
         if (excep_badv_we_i) badv <= excep_badv_wdata_i;
      end else if (ertn_act) begin
         crmd_plv <= prmd_pplv;
         crmd_ie  <= prmd_pie;
      end else if (csr_we_eff) begin
         case (csr_waddr_i)
            ADDR_CRMD: begin
               crmd_plv <= csr_wdata_i[1:0];
               crmd_ie  <= csr_wdata_i[2];
               crmd_da  <= csr_wdata_i[3];
            end
            ADDR_PRMD: begin
               prmd_pplv <= csr_wdata_i[1:0];
               prmd_pie  <= csr_wdata_i[2];
            end
            ADDR_ECFG:   ecfg_lie  <= csr_wdata_i[12:0];
            ADDR_ESTAT:  is_sw     <= csr_wdata_i[1:0];
            ADDR_ERA:    era       <= csr_wdata_i;
            ADDR_BADV:   badv      <= csr_wdata_i;
            ADDR_EENTRY: eentry_hi <= csr_wdata_i[31:6];
            ADDR_TID:    tid       <= csr_wdata_i;
            default: ;
         endcase
      end
   end

`ifdef CSR_TIMER_EN
   logic tcfg_we, ticlr_we, timer_expire;

   assign tcfg_we      = csr_we_eff && (csr_waddr_i == ADDR_TCFG);
   assign ticlr_we     = csr_we_eff && (csr_waddr_i == ADDR_TICLR) && csr_wdata_i[0];
   assign timer_expire = tcfg[0] && (tval == 32'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         tcfg  <= 32'd0;
         tval  <= 32'd0;
         is_ti <= 1'b0;
      end else begin
         if (tcfg_we) begin
            tcfg <= csr_wdata_i;
            if (csr_wdata_i[0]) tval <= {csr_wdata_i[31:2], 2'b00};
         end else if (tcfg[0] && (tval != 32'd0)) begin
            if (tval == 32'd1) tval <= tcfg[1] ? {tcfg[31:2], 2'b00} : 32'd0;
            else               tval <= tval - 32'd1;
         end
         // An expiry in the same cycle as a clear wins so the tick is never lost.
         if (timer_expire)  is_ti <= 1'b1;
         else if (ticlr_we) is_ti <= 1'b0;
      end
   end
`else
   assign tcfg  = 32'd0;
   assign tval  = 32'd0;
   assign is_ti = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) int_req_o <= 1'b0;
      else     int_req_o <= crmd_ie && |(estat_is & ecfg_lie);
   end

   always_comb begin
      csr_rdata_o = 32'd0;
      case (csr_raddr_i)
         ADDR_CRMD:   csr_rdata_o = {28'd0, crmd_da, crmd_ie, crmd_plv};
         ADDR_PRMD:   csr_rdata_o = {29'd0, prmd_pie, prmd_pplv};
         ADDR_ECFG:   csr_rdata_o = {19'd0, ecfg_lie};
         ADDR_ESTAT:  csr_rdata_o = {1'b0, estat_esubcode, estat_ecode, 3'b000, estat_is};
         ADDR_ERA:    csr_rdata_o = era;
         ADDR_BADV:   csr_rdata_o = badv;
         ADDR_EENTRY: csr_rdata_o = {eentry_hi, 6'd0};
         ADDR_TID:    csr_rdata_o = tid;
         ADDR_TCFG:   csr_rdata_o = tcfg;
         ADDR_TVAL:   csr_rdata_o = tval;
         default:     csr_rdata_o = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (excep_en_i || ertn_en_i) state_d = REDIR;
         REDIR:   if (preif_ready_i)           state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      redirect_valid_o = (state_q == REDIR);
   end

   // Target is captured from pre-update ERA/EENTRY and held for the whole REDIR stay.
   always_ff @(posedge clk) begin
      if (rst)          redirect_pc_o <= 32'd0;
      else if (exc_act) redirect_pc_o <= {eentry_hi, 6'd0};
      else if (ertn_act) redirect_pc_o <= era;
   end

endmodule

// File: tb/tb_csr_excp_ctrl.sv
// Directed self-checking bench for csr_excp_ctrl; timer expectations follow CSR_TIMER_EN.
module tb_csr_excp_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        csr_we_i;
   logic [13:0] csr_waddr_i;
   logic [31:0] csr_wdata_i;
   logic [13:0] csr_raddr_i;
   logic [31:0] csr_rdata_o;
   logic [1:0]  cpu_level_o;
   logic        excep_en_i;
   logic [5:0]  excep_ecode_i;
   logic [8:0]  excep_esubcode_i;
   logic [31:0] excep_pc_i;
   logic        excep_badv_we_i;
   logic [31:0] excep_badv_wdata_i;
   logic        ertn_en_i;
   logic        redirect_valid_o;
   logic [31:0] redirect_pc_o;
   logic        preif_ready_i;
   logic        int_req_o;

   int checks = 0;
   int errors = 0;

   csr_excp_ctrl dut (
      .clk(clk), .rst(rst),
      .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i), .csr_wdata_i(csr_wdata_i),
      .csr_raddr_i(csr_raddr_i), .csr_rdata_o(csr_rdata_o), .cpu_level_o(cpu_level_o),
      .excep_en_i(excep_en_i), .excep_ecode_i(excep_ecode_i),
      .excep_esubcode_i(excep_esubcode_i), .excep_pc_i(excep_pc_i),
      .excep_badv_we_i(excep_badv_we_i), .excep_badv_wdata_i(excep_badv_wdata_i),
      .ertn_en_i(ertn_en_i), .redirect_valid_o(redirect_valid_o),
      .redirect_pc_o(redirect_pc_o), .preif_ready_i(preif_ready_i), .int_req_o(int_req_o)
   );

   always #10 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_chk(input string tag, input logic [13:0] addr, input logic [31:0] exp);
      csr_raddr_i = addr;
      #1;
      chk_eq(tag, csr_rdata_o, exp);
   endtask

   task automatic wr(input logic [13:0] addr, input logic [31:0] data);
      csr_we_i    = 1'b1;
      csr_waddr_i = addr;
      csr_wdata_i = data;
      tick();
      csr_we_i    = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1; csr_we_i = 1'b0; csr_waddr_i = '0; csr_wdata_i = '0; csr_raddr_i = '0;
      excep_en_i = 1'b0; excep_ecode_i = '0; excep_esubcode_i = '0; excep_pc_i = '0;
      excep_badv_we_i = 1'b0; excep_badv_wdata_i = '0; ertn_en_i = 1'b0; preif_ready_i = 1'b0;
      repeat (2) tick();
      rst = 1'b0;

      // reset state
      rd_chk("rst_crmd", 14'h000, 32'h8);
      rd_chk("rst_prmd", 14'h001, 32'h0);
      rd_chk("rst_estat", 14'h005, 32'h0);
      chk_eq("rst_valid", {31'd0, redirect_valid_o}, 32'd0);
      chk_eq("rst_pc", redirect_pc_o, 32'd0);
      chk_eq("rst_int", {31'd0, int_req_o}, 32'd0);
      rd_chk("unimpl", 14'h123, 32'h0);

      wr(14'h00C, 32'h1C00_803F);
      rd_chk("eentry_mask", 14'h00C, 32'h1C00_8000);
      wr(14'h000, 32'h7);
      rd_chk("crmd_wr", 14'h000, 32'h7);
      chk_eq("plv3", {30'd0, cpu_level_o}, 32'd3);

      // exception entry
      excep_en_i = 1'b1; excep_ecode_i = 6'h0B; excep_esubcode_i = 9'h1;
      excep_pc_i = 32'h1C00_0100; excep_badv_we_i = 1'b1; excep_badv_wdata_i = 32'h1234_5678;
      tick();
      excep_en_i = 1'b0; excep_badv_we_i = 1'b0;
      rd_chk("exc_prmd", 14'h001, 32'h7);
      rd_chk("exc_crmd", 14'h000, 32'h0);
      rd_chk("exc_era", 14'h006, 32'h1C00_0100);
      rd_chk("exc_estat", 14'h005, 32'h004B_0000);
      rd_chk("exc_badv", 14'h007, 32'h1234_5678);
      chk_eq("exc_valid", {31'd0, redirect_valid_o}, 32'd1);
      chk_eq("exc_pc", redirect_pc_o, 32'h1C00_8000);

      // hold in REDIR for three cycles, second exception attempted mid-stay
      n = 0;
      for (int i = 0; i < 12; i++) begin
         if (!redirect_valid_o) break;
         n++;
         preif_ready_i = (n >= 4);
         excep_en_i = (n == 2);
         excep_pc_i = (n == 2) ? 32'hAAAA_0000 : 32'h1C00_0100;
         excep_ecode_i = (n == 2) ? 6'h03 : 6'h0B;
         tick();
         if (n == 3) chk_eq("redir_pc_hold", redirect_pc_o, 32'h1C00_8000);
      end
      excep_en_i = 1'b0; preif_ready_i = 1'b0;
      chk_eq("redir_cycles", n, 4);
      chk_eq("redir_done", {31'd0, redirect_valid_o}, 32'd0);
      rd_chk("ign_era", 14'h006, 32'h1C00_0100);
      rd_chk("ign_prmd", 14'h001, 32'h7);
      rd_chk("ign_estat", 14'h005, 32'h004B_0000);

      // exception return
      wr(14'h001, 32'h3);
      ertn_en_i = 1'b1;
      tick();
      ertn_en_i = 1'b0;
      rd_chk("ertn_crmd", 14'h000, 32'h3);
      chk_eq("ertn_plv", {30'd0, cpu_level_o}, 32'd3);
      chk_eq("ertn_valid", {31'd0, redirect_valid_o}, 32'd1);
      chk_eq("ertn_pc", redirect_pc_o, 32'h1C00_0100);
      preif_ready_i = 1'b1;
      tick();
      preif_ready_i = 1'b0;
      chk_eq("ertn_idle", {31'd0, redirect_valid_o}, 32'd0);

      // exception, ertn and ERA write together
      excep_en_i = 1'b1; ertn_en_i = 1'b1; excep_ecode_i = 6'h08; excep_esubcode_i = 9'h0;
      excep_pc_i = 32'h1C00_0200;
      csr_we_i = 1'b1; csr_waddr_i = 14'h006; csr_wdata_i = 32'hDEAD_0000;
      tick();
      excep_en_i = 1'b0; ertn_en_i = 1'b0; csr_we_i = 1'b0;
      rd_chk("pri_era", 14'h006, 32'h1C00_0200);
      rd_chk("pri_prmd", 14'h001, 32'h3);
      rd_chk("pri_crmd", 14'h000, 32'h0);
      rd_chk("pri_badv", 14'h007, 32'h1234_5678);
      rd_chk("pri_estat", 14'h005, 32'h0008_0000);
      chk_eq("pri_pc", redirect_pc_o, 32'h1C00_8000);
      preif_ready_i = 1'b1;
      tick();
      preif_ready_i = 1'b0;

      // software interrupt path and registered int_req_o
      wr(14'h004, 32'h3);
      wr(14'h005, 32'h1);
      rd_chk("estat_sw", 14'h005, 32'h0008_0001);
      chk_eq("int_ie0", {31'd0, int_req_o}, 32'd0);
      wr(14'h000, 32'h4);
      chk_eq("int_lat0", {31'd0, int_req_o}, 32'd0);
      tick();
      chk_eq("int_lat1", {31'd0, int_req_o}, 32'd1);
      wr(14'h005, 32'h0);
      chk_eq("int_clr0", {31'd0, int_req_o}, 32'd1);
      tick();
      chk_eq("int_clr1", {31'd0, int_req_o}, 32'd0);
      wr(14'h005, 32'hFFFF_FFFF);
      rd_chk("estat_mask", 14'h005, 32'h0008_0003);
      wr(14'h005, 32'h0);
      wr(14'h004, 32'h800);

      // timer
      wr(14'h041, 32'h0000_000B);
      rd_chk("ticlr_rd", 14'h044, 32'h0);
`ifdef CSR_TIMER_EN
      rd_chk("tcfg_rd", 14'h041, 32'hB);
      rd_chk("tval_load", 14'h042, 32'd8);
      for (int k = 7; k >= 1; k--) begin
         tick();
         rd_chk($sformatf("tval_%0d", k), 14'h042, k);
      end
      rd_chk("ti_pre", 14'h005, 32'h0008_0000);
      tick();
      rd_chk("tval_reload", 14'h042, 32'd8);
      rd_chk("ti_set", 14'h005, 32'h0008_0800);
      chk_eq("ti_int0", {31'd0, int_req_o}, 32'd0);
      tick();
      chk_eq("ti_int1", {31'd0, int_req_o}, 32'd1);
      rd_chk("tval_7", 14'h042, 32'd7);
      wr(14'h044, 32'h1);
      rd_chk("ti_clr", 14'h005, 32'h0008_0000);
      rd_chk("tval_6", 14'h042, 32'd6);
      tick();
      chk_eq("ti_int_off", {31'd0, int_req_o}, 32'd0);
`else
      rd_chk("tcfg_off", 14'h041, 32'h0);
      rd_chk("tval_off", 14'h042, 32'h0);
      for (int k = 0; k < 12; k++) begin
         tick();
         chk_eq("int_off", {31'd0, int_req_o}, 32'd0);
      end
      rd_chk("ti_off", 14'h005, 32'h0008_0000);
`endif

      // reset in the middle of a redirect
      excep_en_i = 1'b1; excep_pc_i = 32'h1C00_0300;
      tick();
      excep_en_i = 1'b0;
      chk_eq("mid_valid", {31'd0, redirect_valid_o}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_eq("mid_rst_valid", {31'd0, redirect_valid_o}, 32'd0);
      chk_eq("mid_rst_pc", redirect_pc_o, 32'd0);
      rd_chk("mid_rst_crmd", 14'h000, 32'h8);
      rd_chk("mid_rst_era", 14'h006, 32'h0);
      rd_chk("mid_rst_tval", 14'h042, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/csr_excp_ctrl.md
CSR_EXCP_CTRL -- requirements
Module: csr_excp_ctrl

Interface
REQ-001 SHALL have these ports, clock and reset first: clk in 1, the single clock; rst in 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-002 SHALL have these CSR access ports: csr_we_i in 1 write enable; csr_waddr_i in 14 write address; csr_wdata_i in 32 write data; csr_raddr_i in 14 read address; csr_rdata_o out 32 read data; cpu_level_o out 2 CRMD.PLV.
REQ-003 SHALL have these exception and return ports: excep_en_i in 1; excep_ecode_i in 6; excep_esubcode_i in 9; excep_pc_i in 32; excep_badv_we_i in 1; excep_badv_wdata_i in 32; ertn_en_i in 1.
REQ-004 SHALL have these redirect and interrupt ports: redirect_valid_o out 1; redirect_pc_o out 32; preif_ready_i in 1; int_req_o out 1, interrupt pending to the pipeline.

Function
REQ-005 SHALL implement these CSRs: CRMD 0x0 (PLV[1:0], IE[2], DA[3]); PRMD 0x1 (PPLV[1:0], PIE[2]); ECFG 0x4 (LIE[12:0]); ESTAT 0x5 (IS[12:0], Ecode[21:16], EsubCode[30:22]); ERA 0x6; BADV 0x7; EENTRY 0xC ([31:6] writable, [5:0] read as 0); TID 0x40; TCFG 0x41 (En[0], Periodic[1], InitVal[31:2]); TVAL 0x42 (read-only); TICLR 0x44 (write-only, reads 0).
REQ-006 SHALL make csr_rdata_o combinational on csr_raddr_i, returning 0 for unimplemented addresses; writes SHALL take effect at the next edge.
REQ-007 SHALL make ESTAT.IS[1:0] the only software-writable IS bits, with IS[11] being the timer interrupt (TI).
REQ-008 SHALL, on an excep_en_i cycle, set PRMD.PPLV/PIE to CRMD.PLV/IE, clear CRMD.PLV and CRMD.IE, load ERA with excep_pc_i, load ESTAT.Ecode/EsubCode from the inputs, and load BADV with excep_badv_wdata_i if excep_badv_we_i.
REQ-009 SHALL, on an ertn_en_i cycle, restore CRMD.PLV/IE from PRMD.PPLV/PIE.
REQ-010 SHALL, when excep_en_i, ertn_en_i and csr_we_i are high together, apply only the exception update.
REQ-011 SHALL implement a state machine with states IDLE and REDIR, reset to IDLE.
REQ-012 SHALL transition IDLE->REDIR on excep_en_i, latching redirect_pc_o as EENTRY, and on ertn_en_i, latching redirect_pc_o as ERA (the value before any same-cycle update).
REQ-013 SHALL, in REDIR, hold redirect_valid_o=1 with redirect_pc_o stable; REDIR->IDLE when preif_ready_i=1.
REQ-014 SHALL, in REDIR, ignore excep_en_i and ertn_en_i because the pipeline is flushed.
REQ-015 SHALL drive int_req_o = CRMD.IE & |(ESTAT.IS & ECFG.LIE), registered, so it asserts one cycle after the condition becomes true.

Reset
REQ-016 SHALL, on rst, set CRMD=0x8 (DA=1, PLV=0, IE=0), all other CSRs=0, state=IDLE, redirect_valid_o=0, redirect_pc_o=0, int_req_o=0.
REQ-017 SHALL make rst asserted mid-REDIR drop redirect_valid_o at the next edge.
REQ-018 SHALL give rst priority over every other event.

Configuration
REQ-019 SHALL, with macro CSR_TIMER_EN defined, load TVAL with {InitVal,2'b00} on a TCFG write with En=1.
REQ-020 SHALL, with CSR_TIMER_EN defined and while En=1 and TVAL!=0, decrement TVAL by 1 per cycle.
REQ-021 SHALL, with CSR_TIMER_EN defined and at TVAL==1 with En=1, set IS[11], then reload TVAL with {InitVal,2'b00} if Periodic or set it to 0 and hold.
REQ-022 SHALL, with CSR_TIMER_EN defined, clear IS[11] on a TICLR write with bit0=1, and set IS[11] if a same-cycle expiry occurs.
REQ-023 SHALL, with CSR_TIMER_EN defined, give a TCFG write priority over the same-cycle decrement or reload.
REQ-024 SHALL, without CSR_TIMER_EN, read TCFG and TVAL as 0, ignore TCFG and TICLR writes, and keep IS[11] at 0.

Verification
REQ-025 SHALL cover: CRMD=0x7, excep_en_i with ecode=0x0B and pc=0x1C000100, EENTRY=0x1C008000 -> next cycle PRMD=0x7, CRMD.PLV/IE=0, ERA=0x1C000100, redirect_valid_o=1, redirect_pc_o=0x1C008000.
REQ-026 SHALL cover: preif_ready_i held 0 for 3 cycles then 1 -> redirect_valid_o high 4 cycles, then IDLE; a second excep_en_i during REDIR causes no CSR change.
REQ-027 SHALL cover: PRMD=0x3, ertn_en_i -> CRMD.PLV=3 and IE=0, redirect_pc_o=ERA.
REQ-028 SHALL cover: excep_en_i, ertn_en_i and a CSR write to ERA high together -> only the exception update applies and ERA=excep_pc_i.
REQ-029 SHALL cover, with CSR_TIMER_EN: TCFG=0x0000000B (InitVal=2, periodic) -> TVAL 8,7,...,1, IS[11] set on the expiry edge, TVAL reloads to 8; with ECFG.LIE[11]=1 and IE=1, int_req_o=1 next cycle; TICLR=1 clears IS[11].
REQ-030 SHALL cover, without CSR_TIMER_EN: the same TCFG write -> TVAL reads 0 and int_req_o stays 0.
